// File: rtl/lct_l1a_match_nch_if.sv
// lct_l1a_match_nch_if: LCT/L1A match bus between the LCT source/config side (master) and the match block (slave)
// din       : per-channel LCT valid, one bit per bx
// l1a       : level-1 accept strobe shared by all channels
// delay     : nominal LCT-to-L1A latency in bx
// win_pre   : window width on the early side of nominal
// win_post  : window width on the late side of nominal
// l1fd      : fine delay applied to the match output
// dout      : din delayed by delay+1 clocks
// l1a_match : per-channel match pulse
// ready     : history valid and matches enabled
// match_cnt : per-channel 16-bit saturating match counters; only present with LCT_L1A_MATCH_CNT_EN
interface lct_l1a_match_nch_if #(
  parameter int NCH = 7,
  parameter int DW = 7,
  parameter int WW = 3
);
  logic [NCH-1:0] din;
  logic l1a;
  logic [DW-1:0] delay;
  logic [WW-1:0] win_pre;
  logic [WW-1:0] win_post;
  logic [3:0] l1fd;
  logic [NCH-1:0] dout;
  logic [NCH-1:0] l1a_match;
  logic ready;
`ifdef LCT_L1A_MATCH_CNT_EN
  logic [NCH*16-1:0] match_cnt;
`endif
  modport master (
`ifdef LCT_L1A_MATCH_CNT_EN
    input match_cnt,
`endif
    output din, l1a, delay, win_pre, win_post, l1fd,
    input dout, l1a_match, ready
  );
  modport slave (
`ifdef LCT_L1A_MATCH_CNT_EN
    output match_cnt,
`endif
    input din, l1a, delay, win_pre, win_post, l1fd,
    output dout, l1a_match, ready
  );
endinterface

// File: rtl/lct_l1a_match_nch.sv
// lct_l1a_match_nch: multi-channel LCT delay line with programmable L1A match window, fine delay and settle interlock
// clk_i : 40 MHz bx clock
// rst_i : synchronous active-high reset; flushes history, fine-delay line and outputs
// bus   : slave side of lct_l1a_match_nch_if (LCT inputs, config, delayed LCT, match pulses, ready)
// Optional LCT_L1A_MATCH_CNT_EN adds per-channel saturating match counters on bus.match_cnt.
module lct_l1a_match_nch #(
  parameter int NCH = 7,
  parameter int DW = 7,
  parameter int WW = 3
) (
  input logic clk_i,
  input logic rst_i,
  lct_l1a_match_nch_if.slave bus
);
  localparam int HD = 2**DW + 2**WW;
  localparam int CW = DW + WW;
  typedef enum logic [1:0] {IDLE_RST, SETTLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, load;
  logic [DW+2*WW-1:0] cfg_q;
  logic chg, ready;
  logic [NCH-1:0][HD-1:0] h_q;
  logic [NCH-1:0][HD:0] sr;
  logic [HD:0] win;
  logic [NCH-1:0] dout_d, dout_q, pre_match;
  logic [15:0][NCH-1:0] pm_q;
  // Config change is seen combinationally against last cycle's copy, so an L1A coincident with it is blocked
  assign chg = {bus.delay, bus.win_pre, bus.win_post} != cfg_q;
  assign load = CW'(bus.delay) + CW'(bus.win_pre) + CW'(1);
  always_ff @(posedge clk_i) begin
    cfg_q <= {bus.delay, bus.win_pre, bus.win_post};
    if (rst_i) begin
      state_q <= IDLE_RST;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // Leaving SETTLE when the count would hit 0 keeps READY low for exactly the loaded number of clocks
  always_comb begin
    state_d = state_q == IDLE_RST || chg ? SETTLE : state_q == SETTLE && cnt_q <= CW'(1) ? RUN : state_q;
    cnt_d = state_q == IDLE_RST || chg ? load : state_q == SETTLE ? (cnt_q <= CW'(1) ? '0 : cnt_q - CW'(1)) : cnt_q;
  end
  always_comb begin
    ready = state_q == RUN;
  end
  // sr[k] is the channel's LCT valid from k bx ago; tap 0 is the live input
  always_comb begin
    for (int i = 0; i < NCH; i++) sr[i] = {h_q[i], bus.din[i]};
  end
  // Window spans ages delay-win_pre .. delay+win_post, clamped at age 0
  always_comb begin
    for (int k = 0; k <= HD; k++)
      win[k] = k >= int'(bus.delay) - int'(bus.win_pre) && k <= int'(bus.delay) + int'(bus.win_post);
  end
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pre_match[i] = bus.l1a & ready & ~chg & |(sr[i] & win);
      dout_d[i] = sr[i][bus.delay];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= '0;
      dout_q <= '0;
      pm_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) h_q[i] <= sr[i][HD-1:0];
      dout_q <= dout_d;
      pm_q <= {pm_q[14:0], pre_match};
    end
  end
  assign bus.dout = dout_q;
  assign bus.l1a_match = pm_q[bus.l1fd];
  assign bus.ready = ready;
`ifdef LCT_L1A_MATCH_CNT_EN
  logic [NCH-1:0][15:0] mc_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) mc_q <= '0;
    else
      for (int i = 0; i < NCH; i++)
        if (bus.l1a_match[i] && mc_q[i] != 16'hFFFF) mc_q[i] <= mc_q[i] + 16'd1;
  end
  assign bus.match_cnt = mc_q;
`endif
endmodule

// File: tb/tb_lct_l1a_match_nch.sv
// tb_lct_l1a_match_nch: directed bench with a cycle model and scoreboard queues for lct_l1a_match_nch
module tb_lct_l1a_match_nch;
  localparam int NCH = 7;
  localparam int DW = 7;
  localparam int WW = 3;
  typedef struct {int cyc; logic [NCH-1:0] m;} ev_t;
  logic clk = 0;
  logic rst = 1;
  int checks = 0, errors = 0, cyc = 0, flush = -1;
  int pulses2 = 0, last0 = -1, last2 = -1, l1a_cyc = 0;
  logic rdy_cur = 0, ready_exp = 0;
  logic [DW+2*WW-1:0] cfg_prev;
  logic [NCH-1:0] hist [0:99999];
  logic [NCH-1:0] dq [$];
  ev_t mq [$];

  lct_l1a_match_nch_if #(.NCH(NCH), .DW(DW), .WW(WW)) bus ();
  lct_l1a_match_nch #(.NCH(NCH), .DW(DW), .WW(WW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] hist_at(int x);
    return (x > flush && x >= 0) ? hist[x] : '0;
  endfunction

  task automatic tick();
    logic [NCH-1:0] m = '0;
    logic [NCH-1:0] me = '0;
    logic [NCH-1:0] de;
    hist[cyc] = bus.din;
    if (rst) begin
      flush = cyc;
      dq.push_back('0);
      mq.delete();
    end else begin
      dq.push_back(hist_at(cyc - int'(bus.delay)));
      if (bus.l1a && rdy_cur && {bus.delay, bus.win_pre, bus.win_post} == cfg_prev)
        for (int k = int'(bus.delay) - int'(bus.win_pre); k <= int'(bus.delay) + int'(bus.win_post); k++)
          if (k >= 0) m |= hist_at(cyc - k);
      if (m != '0) mq.push_back('{cyc + 1 + int'(bus.l1fd), m});
    end
    cfg_prev = {bus.delay, bus.win_pre, bus.win_post};
    @(posedge clk);
    cyc++;
    #1;
    de = dq.pop_front();
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].cyc == cyc) begin
        me |= mq[i].m;
        mq.delete(i);
      end
    if (bus.l1a_match[2]) begin
      pulses2++;
      last2 = cyc;
    end
    if (bus.dout[0]) last0 = cyc;
    checks++;
    assert (bus.dout === de) else begin
      errors++;
      $error("FAIL dout cyc=%0d got=%b exp=%b", cyc, bus.dout, de);
    end
    checks++;
    assert (bus.l1a_match === me) else begin
      errors++;
      $error("FAIL l1a_match cyc=%0d got=%b exp=%b", cyc, bus.l1a_match, me);
    end
    checks++;
    assert (bus.ready === ready_exp) else begin
      errors++;
      $error("FAIL ready cyc=%0d got=%b exp=%b", cyc, bus.ready, ready_exp);
    end
    rdy_cur = ready_exp;
  endtask

  task automatic settle(int n);
    ready_exp = 0;
    repeat (n) tick();
    ready_exp = 1;
    tick();
  endtask

  initial begin
    int t0;
    bus.din = '0;
    bus.l1a = 0;
    bus.delay = 20;
    bus.win_pre = 3;
    bus.win_post = 1;
    bus.l1fd = 0;
    cfg_prev = {bus.delay, bus.win_pre, bus.win_post};
    repeat (3) tick();
    rst = 0;
    settle(24);
    t0 = cyc;
    bus.din[0] = 1;
    tick();
    bus.din = '0;
    repeat (25) tick();
    checks++;
    assert (last0 === t0 + 21) else begin
      errors++;
      $error("FAIL dout_latency got=%0d exp=%0d", last0, t0 + 21);
    end
    bus.delay = 40;
    settle(44);
    pulses2 = 0;
    for (int d = 36; d <= 42; d++) begin
      bus.din[2] = 1;
      tick();
      bus.din = '0;
      repeat (d - 1) tick();
      bus.l1a = 1;
      tick();
      bus.l1a = 0;
      repeat (20) tick();
    end
    checks++;
    assert (pulses2 === 5) else begin
      errors++;
      $error("FAIL window_pulses got=%0d exp=%0d", pulses2, 5);
    end
    bus.l1fd = 9;
    bus.din[2] = 1;
    tick();
    bus.din = '0;
    repeat (37) tick();
    l1a_cyc = cyc;
    bus.l1a = 1;
    tick();
    bus.l1a = 0;
    repeat (20) tick();
    checks++;
    assert (last2 === l1a_cyc + 10) else begin
      errors++;
      $error("FAIL fine_delay9 got=%0d exp=%0d", last2, l1a_cyc + 10);
    end
    bus.l1fd = 15;
    bus.din[2] = 1;
    tick();
    bus.din = '0;
    repeat (39) tick();
    l1a_cyc = cyc;
    bus.l1a = 1;
    tick();
    bus.l1a = 0;
    repeat (20) tick();
    checks++;
    assert (last2 === l1a_cyc + 16) else begin
      errors++;
      $error("FAIL fine_delay15 got=%0d exp=%0d", last2, l1a_cyc + 16);
    end
    bus.l1fd = 0;
    repeat (20) tick();
    bus.din[3] = 1;
    tick();
    bus.din = '0;
    repeat (39) tick();
    ready_exp = 0;
    bus.l1a = 1;
    bus.win_pre = 5;
    bus.din[1] = 1;
    tick();
    bus.l1a = 0;
    bus.din = '0;
    repeat (34) tick();
    bus.l1a = 1;
    tick();
    bus.l1a = 0;
    repeat (10) tick();
    ready_exp = 1;
    tick();
    repeat (10) tick();
    for (int d = 34; d <= 35; d++) begin
      bus.din[4] = 1;
      tick();
      bus.din = '0;
      repeat (d - 1) tick();
      bus.l1a = 1;
      tick();
      bus.l1a = 0;
      repeat (20) tick();
    end
    bus.l1fd = 15;
    repeat (20) tick();
    bus.din = '1;
    repeat (50) tick();
    bus.l1a = 1;
    tick();
    bus.l1a = 0;
    repeat (3) tick();
    bus.din = '0;
    ready_exp = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 46; i++) begin
      bus.l1a = (i % 5 == 2);
      tick();
    end
    bus.l1a = 0;
    ready_exp = 1;
    tick();
    bus.l1a = 1;
    repeat (3) tick();
    bus.l1a = 0;
    bus.din[5] = 1;
    tick();
    bus.din = '0;
    repeat (45) tick();
`ifdef LCT_L1A_MATCH_CNT_EN
    checks++;
    assert (bus.match_cnt[31:0] === 32'd0) else begin
      errors++;
      $error("FAIL cnt_clear got=%h exp=%h", bus.match_cnt[31:0], 32'd0);
    end
    bus.delay = 0;
    bus.win_pre = 0;
    bus.win_post = 0;
    bus.l1fd = 0;
    settle(1);
    bus.din[0] = 1;
    bus.l1a = 1;
    repeat (70000) tick();
    bus.din = '0;
    bus.l1a = 0;
    repeat (5) tick();
    checks++;
    assert (bus.match_cnt[15:0] === 16'hFFFF) else begin
      errors++;
      $error("FAIL cnt_sat got=%h exp=%h", bus.match_cnt[15:0], 16'hFFFF);
    end
    checks++;
    assert (bus.match_cnt[31:16] === 16'h0000) else begin
      errors++;
      $error("FAIL cnt_ch1 got=%h exp=%h", bus.match_cnt[31:16], 16'h0000);
    end
`endif
    repeat (20) tick();
    checks++;
    assert (mq.size() === 0) else begin
      errors++;
      $error("FAIL pending_matches got=%0d exp=%0d", mq.size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
